// File: rtl/dma_cmd_queue.sv
// rtl/dma_cmd_queue.sv - command FIFO feeding a single-request DMA controller handshake
//
// Purpose
//   Buffers up to DEPTH transfer commands {src, dst, mode} from a host and
//   issues them one at a time to an external DMA controller. Each command is
//   presented on dsaddr/ddaddr/dmode with a one-cycle active-low dreq_ strobe.
//   The command leaves the queue when the controller answers with eop_ low. It
//   also leaves the queue when no answer arrives within TMO cycles. In that
//   case the sticky err flag is raised.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready  host push handshake; cmd_ready = (level < DEPTH)
//   cmd_src/dst/mode     command payload written on an accepted push
//   dsaddr/ddaddr/dmode  registered command to the DMA controller
//   dreq_                active-low start strobe, low one cycle per command
//   eop_                 active-low end of transfer, honoured only in XFER
//   busy                 a command is in flight (REQ or XFER)
//   level                FIFO occupancy 0..DEPTH
//   done_cnt             completed (non-timeout) transfers, wraps mod 256
//   irq                  one-cycle pulse when a pop leaves the queue empty
//   err, err_clr         sticky timeout flag and its clear
//
// The level port is 3 bits wide, so DEPTH is limited to 2 or 4.
// TMO must lie in 1..255.

module dma_cmd_queue #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4,
    parameter int TMO    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [1:0]        cmd_mode,
    output logic [ADDR_W-1:0] dsaddr,
    output logic [ADDR_W-1:0] ddaddr,
    output logic [1:0]        dmode,
    output logic              dreq_,
    input  logic              eop_,
    output logic              busy,
    output logic [2:0]        level,
    output logic [7:0]        done_cnt,
    output logic              irq,
    output logic              err,
    input  logic              err_clr
);

    localparam int         PTR_W    = $clog2(DEPTH);
    localparam int         ENT_W    = 2 * ADDR_W + 2;
    localparam logic [2:0] LVL_FULL = 3'(DEPTH);
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Storage and registers
    // ------------------------------------------------------------------
    logic [ENT_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [2:0]        r_level;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_dsaddr;
    logic [ADDR_W-1:0] r_ddaddr;
    logic [1:0]        r_dmode;
    logic              r_dreq_n;
    logic [7:0]        r_tmo_cnt;
    logic [7:0]        r_done_cnt;
    logic              r_irq;
    logic              r_err;
    // Set for the cycle right after a pop. It keeps the next dreq_ off
    // until the controller has had a full cycle to release eop_.
    logic              r_guard;

    logic              w_ready;
    logic              w_push;
    logic              w_launch;
    logic              w_pop;
    logic              w_done;
    logic              w_timeout;
    logic [ENT_W-1:0]  w_wr_entry;
    logic [ENT_W-1:0]  w_head;

    // ------------------------------------------------------------------
    // Push side
    // ------------------------------------------------------------------
    // Ready depends only on the registered level. A pop in the same cycle
    // therefore cannot let a push into a full queue.
    assign w_ready    = (r_level < LVL_FULL);
    assign w_push     = cmd_valid & w_ready;
    assign w_wr_entry = {cmd_src, cmd_dst, cmd_mode};
    assign w_head     = r_mem[r_rptr];

    // The payload RAM needs no reset; the pointers and level decide which
    // entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= 3'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 3'd1;
                2'b01:   r_level <= r_level - 3'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Dispatch FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((r_level != 3'd0) && !r_guard) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                w_state_nxt = ST_XFER;
            end
            ST_XFER: begin
                // eop_ wins over timeout when both occur on the final cycle.
                if (!eop_) begin
                    w_pop       = 1'b1;
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_pop       = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Controller-facing registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dsaddr <= '0;
            r_ddaddr <= '0;
            r_dmode  <= 2'd0;
            r_dreq_n <= 1'b1;
        end else begin
            // Addresses load only at launch. They stay frozen through REQ
            // and XFER and keep their last value while idle.
            if (w_launch) begin
                r_dsaddr <= w_head[ENT_W-1 -: ADDR_W];
                r_ddaddr <= w_head[ENT_W-ADDR_W-1 -: ADDR_W];
                r_dmode  <= w_head[1:0];
            end
            // Low only in the cycle following a launch, i.e. during REQ.
            r_dreq_n <= ~w_launch;
        end
    end

    // Counts XFER cycles that saw eop_ high. It is restarted in REQ so every
    // command gets the full TMO window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= 8'd0;
        end else if (r_state == ST_REQ) begin
            r_tmo_cnt <= 8'd0;
        end else if ((r_state == ST_XFER) && eop_) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Status: completion count, drain interrupt, timeout flag, pop guard
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done_cnt <= 8'd0;
            r_irq      <= 1'b0;
            r_err      <= 1'b0;
            r_guard    <= 1'b0;
        end else begin
            if (w_done) begin
                r_done_cnt <= r_done_cnt + 8'd1;
            end
            // Drain = popping the last entry with nothing arriving to refill.
            r_irq   <= w_pop & (r_level == 3'd1) & ~w_push;
            r_guard <= w_pop;
            // A timeout beats a simultaneous clear so no event is lost.
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_ready = w_ready;
    assign dsaddr    = r_dsaddr;
    assign ddaddr    = r_ddaddr;
    assign dmode     = r_dmode;
    assign dreq_     = r_dreq_n;
    assign busy      = (r_state != ST_IDLE);
    assign level     = r_level;
    assign done_cnt  = r_done_cnt;
    assign irq       = r_irq;
    assign err       = r_err;

endmodule

// File: tb/tb_dma_cmd_queue.sv
// tb/tb_dma_cmd_queue.sv - scoreboard bench for dma_cmd_queue with a DMA controller model

module tb_dma_cmd_queue;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;
    localparam int TMO    = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_src;
    logic [ADDR_W-1:0] cmd_dst;
    logic [1:0]        cmd_mode;
    logic [ADDR_W-1:0] dsaddr;
    logic [ADDR_W-1:0] ddaddr;
    logic [1:0]        dmode;
    logic              dreq_;
    logic              eop_;
    logic              busy;
    logic [2:0]        level;
    logic [7:0]        done_cnt;
    logic              irq;
    logic              err;
    logic              err_clr;

    dma_cmd_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TMO(TMO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_mode(cmd_mode),
        .dsaddr(dsaddr), .ddaddr(ddaddr), .dmode(dmode),
        .dreq_(dreq_), .eop_(eop_),
        .busy(busy), .level(level), .done_cnt(done_cnt),
        .irq(irq), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int          total    = 0;
    int          bad      = 0;
    int          irq_cnt  = 0;
    int          stab_bad = 0;
    int          exp_done = 0;   // eop_ pulses the controller model has issued
    int          eop_lat  = -1;  // 0: never answer, -1: random 1..8, else fixed
    logic [33:0] exp_q[$];       // accepted commands awaiting dispatch
    logic [33:0] launched = '0;
    logic        prev_dreq = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Offers one command for one edge; acceptance follows the valid/ready rule.
    task automatic push(input logic [15:0] s, input logic [15:0] d, input logic [1:0] m,
                        output bit acc);
        cmd_valid = 1'b1;
        cmd_src   = s;
        cmd_dst   = d;
        cmd_mode  = m;
        @(negedge clk);
        acc = (cmd_ready === 1'b1) && (reset === 1'b0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (acc) exp_q.push_back({s, d, m});
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (!(busy === 1'b0 && level === 3'd0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, n < 400, 1);
        repeat (2) @(negedge clk);
        sync();
    endtask

    // DMA controller model: answers each dreq_ with a one-cycle eop_ pulse
    // driven after eop_lat further edges.
    initial begin
        int cd = 0;
        eop_ = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            eop_ = 1'b1;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    eop_ = 1'b0;
                    exp_done++;
                end
            end else if (dreq_ === 1'b0) begin
                if (eop_lat < 0) cd = $urandom_range(1, 8);
                else cd = eop_lat;
            end
        end
    end

    // Monitor: every dreq_ fall must carry the oldest outstanding command.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                prev_dreq = 1'b1;
            end else begin
                if (irq === 1'b1) irq_cnt++;
                if (dreq_ === 1'b0) begin
                    check("dreq_one_cycle", prev_dreq, 1);
                    if (prev_dreq === 1'b1) begin
                        launched = {dsaddr, ddaddr, dmode};
                        check("dispatch_pending", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0)
                            check("dispatch_order", {dsaddr, ddaddr, dmode}, exp_q.pop_front());
                    end
                end else if (busy === 1'b1 && {dsaddr, ddaddr, dmode} !== launched) begin
                    stab_bad++;
                end
                prev_dreq = dreq_;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        bit          acc;
        bit          accs[5];
        int          irq0;
        int          d0;
        int          n;
        int          n_acc;
        int          iter;
        logic [33:0] rv;

        reset = 1'b1; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_mode = '0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dreq", dreq_, 1);
        check("rst_addr", {dsaddr, ddaddr, dmode}, 0);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        check("rst_done", done_cnt, 0);
        check("rst_irq_err", {irq, err}, 0);
        check("rst_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sync();

        // Single command, controller answers 6 cycles after dreq_ falls.
        eop_lat = 6; irq0 = irq_cnt;
        push(16'h0010, 16'h0080, 2'd0, acc);
        check("single_acc", acc, 1);
        @(negedge clk);
        check("single_pre_dreq", dreq_, 1);
        check("single_level", level, 1);
        @(negedge clk);
        check("single_dreq_low", dreq_, 0);
        check("single_src_dst", {dsaddr, ddaddr}, 32'h0010_0080);
        check("single_busy", busy, 1);
        @(negedge clk);
        check("single_dreq_rel", dreq_, 1);
        wait_idle("single_idle");
        check("single_done", done_cnt, 1);
        check("single_irq", irq_cnt - irq0, 1);
        check("single_level_end", level, 0);

        // Full queue: five back-to-back offers, the fifth must bounce.
        eop_lat = 8; irq0 = irq_cnt;
        for (int i = 0; i < 5; i++) begin
            rv = {$urandom, $urandom};
            push(rv[33:18], rv[17:2], rv[1:0], accs[i]);
        end
        check("full_first4", {accs[0], accs[1], accs[2], accs[3]}, 4'hf);
        check("full_fifth_rejected", accs[4], 0);
        @(negedge clk);
        check("full_level4", level, 4);
        check("full_ready", cmd_ready, 0);
        n = 0;
        while (level === 3'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("full_level3", level, 3);
        check("full_no_err", err, 0);
        wait_idle("full_idle");
        check("full_done", done_cnt, 8'(exp_done));
        check("full_irq", irq_cnt - irq0, 1);

        // Push and pop on the same edge at level 2.
        eop_lat = 4; irq0 = irq_cnt;
        push(16'hA001, 16'hA002, 2'd1, acc);
        push(16'hB001, 16'hB002, 2'd2, acc);
        repeat (4) sync();
        push(16'hC001, 16'hC002, 2'd3, acc);
        check("pp_acc", acc, 1);
        @(negedge clk);
        check("pp_level", level, 2);
        repeat (2) @(negedge clk);
        check("pp_next_dreq", dreq_, 0);
        check("pp_next_is_b", {dsaddr, ddaddr, dmode}, {16'hB001, 16'hB002, 2'd2});
        check("pp_no_irq", irq_cnt - irq0, 0);
        wait_idle("pp_idle");
        check("pp_irq_drain", irq_cnt - irq0, 1);
        check("pp_done", done_cnt, 8'(exp_done));

        // Timeout: controller never answers.
        eop_lat = 0; irq0 = irq_cnt; d0 = exp_done;
        push(16'h1234, 16'h5678, 2'd1, acc);
        repeat (10) @(negedge clk);
        check("tmo_err_early", err, 0);
        @(negedge clk);
        check("tmo_err_set", err, 1);
        check("tmo_busy", busy, 0);
        check("tmo_done_same", done_cnt, 8'(d0));
        sync();
        err_clr = 1'b1;
        sync();
        err_clr = 1'b0;
        @(negedge clk);
        check("tmo_err_clr", err, 0);
        sync();

        // Timeout on the same edge as err_clr: err must end up set.
        push(16'h4321, 16'h8765, 2'd2, acc);
        err_clr = 1'b1;
        repeat (9) sync();
        @(negedge clk);
        check("prio_before", err, 0);
        sync();
        err_clr = 1'b0;
        @(negedge clk);
        check("prio_err", err, 1);
        wait_idle("tmo_idle");
        check("tmo_err_sticky", err, 1);
        check("tmo_irq", irq_cnt - irq0, 2);
        check("tmo_done_end", done_cnt, 8'(d0));
        err_clr = 1'b1;
        sync();
        err_clr = 1'b0;

        // Reset during XFER with three entries queued; push in reset cycle.
        eop_lat = 8; irq0 = irq_cnt;
        push(16'h0101, 16'h0202, 2'd0, acc);
        push(16'h0303, 16'h0404, 2'd1, acc);
        push(16'h0505, 16'h0606, 2'd2, acc);
        sync();
        reset = 1'b1; cmd_valid = 1'b1; cmd_src = 16'hDEAD; cmd_dst = 16'hBEEF;
        sync();
        reset = 1'b0; cmd_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rstx_level", level, 0);
        check("rstx_dreq", dreq_, 1);
        check("rstx_busy", busy, 0);
        check("rstx_irq", irq, 0);
        repeat (14) @(negedge clk);
        check("rstx_eop_ignored", {busy, level, dreq_}, 5'b0_000_1);
        check("rstx_done", done_cnt, 0);
        check("rstx_no_irq", irq_cnt - irq0, 0);
        exp_done = 0;
        sync();

        // 257 random transfers: done_cnt wraps, pointers wrap many times.
        eop_lat = -1; n_acc = 0; iter = 0;
        while (n_acc < 257 && iter < 20000) begin
            if ($urandom_range(0, 3) == 0) begin
                sync();
            end else begin
                rv = {$urandom, $urandom};
                push(rv[33:18], rv[17:2], rv[1:0], acc);
                if (acc) n_acc++;
            end
            iter++;
        end
        wait_idle("wrap_idle");
        check("wrap_completions", exp_done, 257);
        check("wrap_done_cnt", done_cnt, 1);
        check("wrap_none_lost", exp_q.size(), 0);
        check("wrap_level", level, 0);
        check("wrap_no_err", err, 0);
        check("outputs_stable", stab_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_cmd_queue.md
DMA_CMD_QUEUE -- requirements
Module: dma_cmd_queue

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W  16  bus address width, equal to `BUS_ADDR_WIDTH
  DEPTH  4  command FIFO entries, power of two
  TMO  255  max cycles waiting for eop_ before abort, 1..255
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  sole clock, rising edge
  reset  in  1  synchronous, active-high
  cmd_valid  in  1  host offers a command
  cmd_ready  out  1  queue can accept a command
  cmd_src  in  ADDR_W  transfer source address
  cmd_dst  in  ADDR_W  transfer destination address
  cmd_mode  in  2  transfer mode, passed through unchanged
  dsaddr  out  ADDR_W  source address to DMA controller
  ddaddr  out  ADDR_W  destination address to DMA controller
  dmode  out  2  mode to DMA controller
  dreq_  out  1  active-low DMA start request
  eop_  in  1  active-low end-of-transfer from DMA controller
  busy  out  1  a transfer is outstanding
  level  out  3  FIFO occupancy, 0..DEPTH
  done_cnt  out  8  completed transfers, wraps 255->0
  irq  out  1  one-cycle pulse when the queue drains
  err  out  1  sticky timeout flag
  err_clr  in  1  clears err

Function
REQ-003 Push: {cmd_src,cmd_dst,cmd_mode} SHALL be written at an edge where cmd_valid=1 and cmd_ready=1.
REQ-004 cmd_ready SHALL be combinational: 1 when level<DEPTH; a same-cycle pop SHALL NOT raise cmd_ready when full.
REQ-005 The FSM SHALL have states IDLE, REQ, XFER.
REQ-006 IDLE: if level>0, register the head entry onto dsaddr/ddaddr/dmode, drive dreq_=0, and go to REQ.
REQ-007 REQ: lasts exactly one cycle; drive dreq_=1, clear the timeout counter, and go to XFER. dreq_ is therefore low for exactly one cycle per command.
REQ-008 XFER: dsaddr/ddaddr/dmode SHALL be held stable. On sampling eop_=0: pop the head entry, increment done_cnt, and go to IDLE.
REQ-009 XFER timeout: if eop_ stays 1 for TMO cycles, set err=1, pop the head entry without incrementing done_cnt, and go to IDLE.
REQ-010 After a pop, the next dreq_ SHALL fall no earlier than 2 edges later, so the controller never sees dreq_ low while eop_ is low.
REQ-011 Latency: a command pushed at edge t into an empty queue with the FSM in IDLE SHALL give dreq_=0 from edge t+1 to edge t+2.
REQ-012 busy SHALL be 1 in REQ and XFER, and 0 in IDLE.
REQ-013 level SHALL change by +1 on a push, -1 on a pop, and 0 when both happen in the same cycle.
REQ-014 FIFO read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-015 irq SHALL be 1 for one cycle, at the edge after a pop that leaves level=0 with no push in the same cycle; this applies to both normal and timeout pops.
REQ-016 err SHALL clear on err_clr=1 only. A timeout in the same cycle as err_clr=1 SHALL take priority and leave err=1.
REQ-017 eop_=0 sampled in IDLE or REQ SHALL be ignored.

Reset
REQ-018 reset=1 at an edge SHALL empty the FIFO and force FSM=IDLE, dreq_=1, dsaddr=0, ddaddr=0, dmode=0, busy=0, level=0, done_cnt=0, irq=0, err=0. cmd_ready then reads 1.
REQ-019 A reset mid-transfer SHALL discard all queued and in-flight commands without any irq. Pushes in the reset cycle SHALL be dropped.

Verification
REQ-020 Single command: push src=0x0010, dst=0x0080, mode=0 at edge 1; assert eop_ low 6 cycles after dreq_ falls.
  Required: dreq_ low for exactly 1 cycle from edge 2; outputs stable until eop_; done_cnt=1; irq pulses once; level=0.
REQ-021 Full queue: push 5 commands back-to-back with eop_ held high.
  Required: cmd_ready=0 after the 4th push; the 5th command is not accepted; level=4, then 3 after a pop.
REQ-022 Simultaneous push and pop at level=2.
  Required: level stays 2; order preserved; the next dreq_ carries the old 2nd entry; no irq.
REQ-023 Timeout with TMO=8 and eop_ never asserted.
  Required: err=1 exactly 8 cycles after the REQ cycle; done_cnt unchanged; irq pulses; err_clr clears err.
REQ-024 Reset during XFER with 3 entries queued.
  Required: next cycle level=0, dreq_=1, busy=0, no irq; eop_=0 arriving afterwards is ignored.
REQ-025 Wrap: complete 257 transfers.
  Required: done_cnt=1; FIFO pointer wrap causes no lost or duplicated commands.
